alu_pipe: RTL

- Parametrised, single-stage registered ALU for the execute stage of the pipeline processor.
- Accepts one operation per cycle through a valid/ready handshake and registers the result.
- Holds the architectural condition-code register (Z, N, C) and supports explicit flag set/clear and flag restore for interrupt return.
- Successor of the fixed 16-bit combinational ALU: width-generic, expanded opcode set, back-pressure, registered flags.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_core.sv | 110 +++++++++++
 rtl/alu_pipe.sv | 99 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the execute-stage ALU.
//   Opcode encodings (OP_NOP .. OP_SHR), condition-code bit indices
//   (FLAG_Z, FLAG_N, FLAG_C), the 3-bit flag vector type and the
//   per-opcode flag-update masks used by alu_core.
package alu_pkg;

  localparam int OP_BITS = 4;
  typedef logic [OP_BITS-1:0] op_t;

  localparam op_t OP_NOP    = 4'd0;
  localparam op_t OP_ADD    = 4'd1;
  localparam op_t OP_SUB    = 4'd2;
  localparam op_t OP_AND    = 4'd3;
  localparam op_t OP_OR     = 4'd4;
  localparam op_t OP_NOT    = 4'd5;
  localparam op_t OP_PASS_A = 4'd6;
  localparam op_t OP_PASS_B = 4'd7;
  localparam op_t OP_INC    = 4'd8;
  localparam op_t OP_DEC    = 4'd9;
  localparam op_t OP_SETC   = 4'd10;
  localparam op_t OP_CLRC   = 4'd11;
  localparam op_t OP_SHL    = 4'd12;
  localparam op_t OP_SHR    = 4'd13;

  // Flag vector layout is {C,N,Z}.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef logic [2:0] flag_t;

  localparam flag_t FLAGS_NONE = 3'b000;
  localparam flag_t FLAGS_ALL  = 3'b111;
  localparam flag_t FLAGS_ZN   = 3'b011;
  localparam flag_t FLAGS_C    = 3'b100;

endpackage

// File: rtl/alu_core.sv
// alu_core -- combinational ALU datapath.
//   Ports:
//     op     in   opcode (alu_pkg encoding)
//     a, b   in   WIDTH operands
//     c_in   in   current carry flag (carried through when unchanged)
//     result out  WIDTH result
//     carry  out  new carry value
//     mask   out  which flags ({C,N,Z}) this opcode updates
//   Macro ALU_SHIFT_EN: when defined, OP_SHL/OP_SHR shift; otherwise they
//   fall through to NOP behaviour and no shifter is built.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic [2:0]       mask
);

`ifdef ALU_SHIFT_EN
  localparam int SHW = $clog2(WIDTH);
  logic [SHW-1:0] sh;
  assign sh = b[SHW-1:0];
`endif

  // One extra bit on top catches carry-out / borrow for add and subtract.
  logic [WIDTH:0] wide;

  always_comb begin
    result = a;
    carry  = c_in;
    mask   = FLAGS_NONE;
    wide   = '0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
        mask   = FLAGS_ALL;
      end
      OP_SUB: begin
        // Top bit of the extended difference is set exactly when a < b.
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
        mask   = FLAGS_ALL;
      end
      OP_AND: begin
        result = a & b;
        mask   = FLAGS_ZN;
      end
      OP_OR: begin
        result = a | b;
        mask   = FLAGS_ZN;
      end
      OP_NOT: begin
        result = ~b;
        mask   = FLAGS_ZN;
      end
      OP_PASS_B: begin
        result = b;
      end
      OP_INC: begin
        wide   = {1'b0, b} + (WIDTH+1)'(1);
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
        mask   = FLAGS_ALL;
      end
      OP_DEC: begin
        wide   = {1'b0, b} - (WIDTH+1)'(1);
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
        mask   = FLAGS_ALL;
      end
      OP_SETC: begin
        carry = 1'b1;
        mask  = FLAGS_C;
      end
      OP_CLRC: begin
        carry = 1'b0;
        mask  = FLAGS_C;
      end
`ifdef ALU_SHIFT_EN
      OP_SHL: begin
        // Bit WIDTH of the widened shift is the last bit pushed out.
        wide   = {1'b0, a} << sh;
        result = wide[WIDTH-1:0];
        carry  = (sh == '0) ? c_in : wide[WIDTH];
        mask   = FLAGS_ALL;
      end
      OP_SHR: begin
        // Bit 0 of the widened shift is the last bit pushed out.
        wide   = {a, 1'b0} >> sh;
        result = wide[WIDTH:1];
        carry  = (sh == '0) ? c_in : wide[0];
        mask   = FLAGS_ALL;
      end
`endif
      default: begin
        // NOP, PASS_A, unused encodings: result = a, no flag update.
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe -- single-stage registered ALU with valid/ready handshake and
// the architectural condition-code register.
//   Ports:
//     clk, rst_n             clock, synchronous active-low reset
//     in_valid/in_ready      input handshake
//     in_op, in_a, in_b      opcode and operands
//     out_valid/out_ready    output handshake
//     out_result, out_flags  registered result and its {C,N,Z} snapshot
//     flags                  current condition-code register {C,N,Z}
//     flag_wr_en/_data       flag restore (interrupt return)
//   Macro ALU_SHIFT_EN enables SHL/SHR in alu_core; default build omits it.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_flags,
  output logic [2:0]       flags,
  input  logic             flag_wr_en,
  input  logic [2:0]       flag_wr_data
);

  op_t              op_p0;
  logic [WIDTH-1:0] res_p0;
  logic             carry_p0;
  flag_t            mask_p0;
  flag_t            calc_p0;
  flag_t            next_flags_p0;
  logic             accept_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] res_p1;
  flag_t            oflags_p1;
  flag_t            flags_q;

  assign op_p0 = op_t'(in_op);

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (op_p0),
    .a      (in_a),
    .b      (in_b),
    .c_in   (flags_q[FLAG_C]),
    .result (res_p0),
    .carry  (carry_p0),
    .mask   (mask_p0)
  );

  always_comb begin
    calc_p0         = '0;
    calc_p0[FLAG_Z] = (res_p0 == '0);
    calc_p0[FLAG_N] = res_p0[WIDTH-1];
    calc_p0[FLAG_C] = carry_p0;
  end

  assign next_flags_p0 = (mask_p0 & calc_p0) | (~mask_p0 & flags_q);
  assign in_ready      = !vld_p1 || out_ready;
  assign accept_p0     = in_valid && in_ready;

  // p0 -> p1: result register and condition codes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      res_p1    <= '0;
      oflags_p1 <= '0;
      flags_q   <= '0;
    end else begin
      if (accept_p0) begin
        vld_p1    <= 1'b1;
        res_p1    <= res_p0;
        oflags_p1 <= next_flags_p0;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
      // A restore overrides the op's update; out_flags still shows the op's.
      if (flag_wr_en) begin
        flags_q <= flag_wr_data;
      end else if (accept_p0) begin
        flags_q <= next_flags_p0;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_result = res_p1;
  assign out_flags  = oflags_p1;
  assign flags      = flags_q;

endmodule
